// File: rtl/lsu_ctrl.sv
// Load/store unit controller: byte/half/word accesses onto a 32-bit single-cycle RAM.
// Define LSU_MISALIGN_EN to split misaligned accesses into two RAM cycles; otherwise they error.
module lsu_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid_i,
  input  logic        req_we_i,
  input  logic [2:0]  req_op_i,
  input  logic [31:0] req_addr_i,
  input  logic [31:0] req_wdata_i,
  output logic        req_ready_o,
  output logic        stall_o,
  output logic        rsp_valid_o,
  output logic [31:0] rsp_rdata_o,
  output logic        rsp_err_o,
  output logic        ram_ce_o,
  output logic        ram_we_o,
  output logic [31:0] ram_addr_o,
  output logic [3:0]  ram_sel_o,
  output logic [31:0] ram_data_o,
  input  logic [31:0] ram_data_i
);

  typedef enum logic [1:0] {StIdle, StPh1, StPh2, StResp} state_e;

  state_e      state_q, state_d;
  logic        we_q;
  logic [2:0]  op_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic        err_q;
  logic [31:0] asm_lo_q;

  logic        accept;
  logic        op_bad;
  logic        misalign_in;
  logic [1:0]  off;
  logic [3:0]  lane_mask;
  logic [31:0] wdata_m;
  logic [31:0] word_addr;
  logic [31:0] ld_raw;
  logic [31:0] ld_ext;
  logic [3:0]  sel_lo;
  logic [31:0] data_lo;

  assign accept = (state_q == StIdle) && req_valid_i;

  // Unsupported funct3 encodings are rejected before any RAM cycle.
  always_comb begin
    op_bad = 1'b0;
    if (req_we_i) begin
      op_bad = req_op_i[2] || (req_op_i[1:0] == 2'b11);
    end else begin
      op_bad = (req_op_i == 3'b011) || (req_op_i[2:1] == 2'b11);
    end
  end

`ifdef LSU_MISALIGN_EN
  assign misalign_in = 1'b0;
`else
  assign misalign_in = ((req_op_i[1:0] == 2'b01) && req_addr_i[0]) ||
                       ((req_op_i[1:0] == 2'b10) && (req_addr_i[1:0] != 2'b00));
`endif

  assign off       = addr_q[1:0];
  assign word_addr = {addr_q[31:2], 2'b00};

  always_comb begin
    lane_mask = 4'b0000;
    wdata_m   = '0;
    unique case (op_q[1:0])
      2'b00: begin
        lane_mask = 4'b0001;
        wdata_m   = {24'h0, wdata_q[7:0]};
      end
      2'b01: begin
        lane_mask = 4'b0011;
        wdata_m   = {16'h0, wdata_q[15:0]};
      end
      2'b10: begin
        lane_mask = 4'b1111;
        wdata_m   = wdata_q;
      end
      default: begin
        lane_mask = 4'b0000;
        wdata_m   = '0;
      end
    endcase
  end

`ifdef LSU_MISALIGN_EN
  logic [31:0] asm_hi_q;
  logic [7:0]  sel_wide;
  logic [63:0] data_wide;
  logic        split;
  logic [3:0]  sel_hi;
  logic [31:0] data_hi;

  // Lanes and data that run past byte 3 spill into the next word's low lanes.
  assign sel_wide  = {4'b0000, lane_mask} << off;
  assign data_wide = {32'h0, wdata_m} << {off, 3'b000};
  assign sel_lo    = sel_wide[3:0];
  assign sel_hi    = sel_wide[7:4];
  assign data_lo   = data_wide[31:0];
  assign data_hi   = data_wide[63:32];
  assign split     = ((op_q[1:0] == 2'b01) && (off == 2'b11)) ||
                     ((op_q[1:0] == 2'b10) && (off != 2'b00));
  assign ld_raw    = 32'({asm_hi_q, asm_lo_q} >> {off, 3'b000});

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      asm_hi_q <= '0;
    end else if (state_q == StPh2) begin
      asm_hi_q <= ram_data_i;
    end
  end
`else
  assign sel_lo  = lane_mask << off;
  assign data_lo = wdata_m << {off, 3'b000};
  assign ld_raw  = asm_lo_q >> {off, 3'b000};
`endif

  always_comb begin
    ld_ext = ld_raw;
    unique case (op_q)
      3'b000:  ld_ext = {{24{ld_raw[7]}}, ld_raw[7:0]};
      3'b001:  ld_ext = {{16{ld_raw[15]}}, ld_raw[15:0]};
      3'b100:  ld_ext = {24'h0, ld_raw[7:0]};
      3'b101:  ld_ext = {16'h0, ld_raw[15:0]};
      default: ld_ext = ld_raw;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      we_q     <= 1'b0;
      op_q     <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      err_q    <= 1'b0;
      asm_lo_q <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        we_q    <= req_we_i;
        op_q    <= req_op_i;
        addr_q  <= req_addr_i;
        wdata_q <= req_wdata_i;
        err_q   <= op_bad || misalign_in;
      end
      if (state_q == StPh1) begin
        asm_lo_q <= ram_data_i;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    req_ready_o = 1'b0;
    stall_o     = 1'b1;
    rsp_valid_o = 1'b0;
    rsp_err_o   = 1'b0;
    rsp_rdata_o = '0;
    ram_ce_o    = 1'b0;
    ram_we_o    = 1'b0;
    ram_addr_o  = '0;
    ram_sel_o   = '0;
    ram_data_o  = '0;
    unique case (state_q)
      StIdle: begin
        req_ready_o = 1'b1;
        stall_o     = req_valid_i;
        if (req_valid_i) begin
          state_d = op_bad ? StResp : StPh1;
        end
      end
      StPh1: begin
        // A misaligned access without split support idles here with the RAM disabled.
        if (!err_q) begin
          ram_ce_o   = 1'b1;
          ram_we_o   = we_q;
          ram_addr_o = word_addr;
          ram_sel_o  = sel_lo;
          ram_data_o = we_q ? data_lo : '0;
        end
`ifdef LSU_MISALIGN_EN
        state_d = (!err_q && split) ? StPh2 : StResp;
`else
        state_d = StResp;
`endif
      end
      StPh2: begin
`ifdef LSU_MISALIGN_EN
        ram_ce_o   = 1'b1;
        ram_we_o   = we_q;
        ram_addr_o = word_addr + 32'd4;
        ram_sel_o  = sel_hi;
        ram_data_o = we_q ? data_hi : '0;
`endif
        state_d = StResp;
      end
      StResp: begin
        rsp_valid_o = 1'b1;
        rsp_err_o   = err_q;
        rsp_rdata_o = (!we_q && !err_q) ? ld_ext : '0;
        state_d     = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

endmodule
